ibex_multdiv_iter: RTL and testbench

IBEX_MULTDIV_ITER -- requirements
Module: ibex_multdiv_iter

---
 rtl/ibex_multdiv_iter.sv | 221 ++++++++++++++++++++++
 tb/tb_ibex_multdiv_iter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ibex_multdiv_iter.sv
// ibex_multdiv_iter: iterative multiply/divide unit for the RV32M operations.
// Shift-add multiply and restoring divide retire STEPS bit-steps per COMP cycle.
// Data-independent timing mode disables every early exit.
module ibex_multdiv_iter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned STEPS = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] op_a_i,
   input  logic [WIDTH-1:0] op_b_i,
   input  logic             data_ind_timing_i,
   input  logic             kill_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             busy_o
);

   localparam int unsigned ITERS = WIDTH / STEPS;
   localparam int unsigned CNT_W = $clog2(ITERS + 1);

   localparam logic [2:0] OpMul    = 3'b000;
   localparam logic [2:0] OpMulh   = 3'b001;
   localparam logic [2:0] OpMulhsu = 3'b010;
   localparam logic [2:0] OpDiv    = 3'b100;
   localparam logic [2:0] OpRem    = 3'b110;

   generate
      if ((WIDTH < 8) || ((WIDTH % 2) != 0)) begin : g_bad_width
         $error("ibex_multdiv_iter: WIDTH must be even and >= 8");
      end
      if (!((STEPS == 1) || (STEPS == 2) || (STEPS == 4) || (STEPS == 8)) ||
          ((WIDTH % STEPS) != 0)) begin : g_bad_steps
         $error("ibex_multdiv_iter: STEPS must be 1, 2, 4 or 8 and divide WIDTH");
      end
   endgenerate

   typedef enum logic [2:0] {StIdle, StPrep, StComp, StFixup, StDone} state_e;

   state_e               state_q, state_d;
   logic [2:0]           op_q, op_d;
   logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
   logic                 dit_q, dit_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [WIDTH:0]       rem_q, rem_d;
   logic [WIDTH-1:0]     quot_q, quot_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]     result_q, result_d;

   logic                 sign_a, sign_b, neg_a, neg_b, is_div, comp_last;
   logic [WIDTH-1:0]     abs_a, abs_b, quot_fix, rem_fix;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [2*WIDTH-1:0]   m_acc, m_cand;
   logic [WIDTH-1:0]     m_plier, d_quot;
   logic [WIDTH:0]       d_rem, d_shift, div_ext;
   logic                 d_ge;

   assign is_div = op_q[2];
   assign sign_a = (op_q == OpMul) | (op_q == OpMulh) | (op_q == OpMulhsu) |
                   (op_q == OpDiv) | (op_q == OpRem);
   assign sign_b = (op_q == OpMul) | (op_q == OpMulh) | (op_q == OpDiv) | (op_q == OpRem);
   assign neg_a  = sign_a & a_q[WIDTH-1];
   assign neg_b  = sign_b & b_q[WIDTH-1];
   assign abs_a  = neg_a ? -a_q : a_q;
   assign abs_b  = neg_b ? -b_q : b_q;

   assign prod_fix = neg_res_q ? -acc_q : acc_q;
   assign quot_fix = neg_res_q ? -quot_q : quot_q;
   assign rem_fix  = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
   // During divide mplier_q holds the unshifted divisor magnitude
   assign div_ext  = {1'b0, mplier_q};

   // Unrolled STEPS bit-steps of both shift-add multiply and restoring divide
   always_comb begin
      m_acc   = acc_q;
      m_cand  = mcand_q;
      m_plier = mplier_q;
      d_rem   = rem_q;
      d_quot  = quot_q;
      d_shift = '0;
      d_ge    = 1'b0;
      for (int i = 0; i < STEPS; i++) begin
         if (m_plier[0]) begin
            m_acc = m_acc + m_cand;
         end
         m_cand  = m_cand << 1;
         m_plier = m_plier >> 1;
         d_shift = {d_rem[WIDTH-1:0], d_quot[WIDTH-1]};
         d_ge    = (d_shift >= div_ext);
         d_rem   = d_ge ? (d_shift - div_ext) : d_shift;
         d_quot  = {d_quot[WIDTH-2:0], d_ge};
      end
   end

   assign comp_last = (cnt_q == CNT_W'(1)) | (~is_div & ~dit_q & (m_plier == '0));

   // Next-state and datapath updates; kill_i overrides everything else
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      dit_d     = dit_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      rem_d     = rem_q;
      quot_d    = quot_q;
      cnt_d     = cnt_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      if (kill_i) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (valid_i) begin
                  op_d  = op_i;
                  a_d   = op_a_i;
                  b_d   = op_b_i;
                  dit_d = data_ind_timing_i;
                  if (op_i[2] && !data_ind_timing_i && (op_b_i == '0)) begin
                     state_d  = StDone;
                     result_d = op_i[1] ? op_a_i : '1;
                  end else begin
                     state_d = StPrep;
                  end
               end
            end
            StPrep: begin
               acc_d     = '0;
               mcand_d   = {{WIDTH{1'b0}}, abs_a};
               mplier_d  = abs_b;
               rem_d     = '0;
               quot_d    = abs_a;
               cnt_d     = CNT_W'(ITERS);
               // A zero divisor keeps the all-ones quotient unsigned
               neg_res_d = (neg_a ^ neg_b) & ~(is_div & (b_q == '0));
               neg_rem_d = neg_a;
               state_d   = StComp;
            end
            StComp: begin
               cnt_d = cnt_q - CNT_W'(1);
               if (is_div) begin
                  rem_d  = d_rem;
                  quot_d = d_quot;
               end else begin
                  acc_d    = m_acc;
                  mcand_d  = m_cand;
                  mplier_d = m_plier;
               end
               if (comp_last) begin
                  state_d = StFixup;
               end
            end
            StFixup: begin
               if (is_div) begin
                  result_d = op_q[1] ? rem_fix : quot_fix;
               end else begin
                  result_d = (op_q == OpMul) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
               end
               state_d = StDone;
            end
            StDone: begin
               if (ready_i) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         dit_q     <= 1'b0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         rem_q     <= '0;
         quot_q    <= '0;
         cnt_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         dit_q     <= dit_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         rem_q     <= rem_d;
         quot_q    <= quot_d;
         cnt_q     <= cnt_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
      end
   end

   assign ready_o  = (state_q == StIdle);
   assign busy_o   = (state_q != StIdle);
   assign valid_o  = (state_q == StDone);
   assign result_o = result_q;

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Directed bench for ibex_multdiv_iter: one STEPS=1 and one STEPS=4 instance.
module tb_ibex_multdiv_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, req_valid, req_ready, kill, dit;
   logic [2:0]  op;
   logic [31:0] a, b;
   int          sel;
   int          n_assert = 0;
   int          n_fail   = 0;

   logic        v_i0, v_i1, r_i0, r_i1, k0, k1;
   logic        rdy0, rdy1, vo0, vo1, busy0, busy1;
   logic [31:0] res0, res1;
   logic        cur_valid, cur_ready, cur_busy;
   logic [31:0] cur_res;

   assign v_i0 = req_valid & (sel == 0);
   assign v_i1 = req_valid & (sel == 1);
   assign r_i0 = req_ready & (sel == 0);
   assign r_i1 = req_ready & (sel == 1);
   assign k0   = kill & (sel == 0);
   assign k1   = kill & (sel == 1);

   assign cur_valid = (sel == 0) ? vo0 : vo1;
   assign cur_ready = (sel == 0) ? rdy0 : rdy1;
   assign cur_busy  = (sel == 0) ? busy0 : busy1;
   assign cur_res   = (sel == 0) ? res0 : res1;

   ibex_multdiv_iter #(.WIDTH(32), .STEPS(1)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .valid_i(v_i0), .ready_o(rdy0), .op_i(op),
      .op_a_i(a), .op_b_i(b), .data_ind_timing_i(dit), .kill_i(k0),
      .valid_o(vo0), .ready_i(r_i0), .result_o(res0), .busy_o(busy0)
   );

   ibex_multdiv_iter #(.WIDTH(32), .STEPS(4)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .valid_i(v_i1), .ready_o(rdy1), .op_i(op),
      .op_a_i(a), .op_b_i(b), .data_ind_timing_i(dit), .kill_i(k1),
      .valid_o(vo1), .ready_i(r_i1), .result_o(res1), .busy_o(busy1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic start(input int s, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic d);
      @(negedge clk);
      sel = s; op = o; a = x; b = y; dit = d; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // Edges counted after the accepting edge until valid_o is seen
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!cur_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("done_in_time", 64'(lat < 200), 64'd1);
   endtask

   task automatic consume();
      @(negedge clk);
      req_ready = 1'b1;
      @(posedge clk);
      #1;
      req_ready = 1'b0;
   endtask

   task automatic run(input string tag, input int s, input logic [2:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic d, input logic [31:0] exp,
                      input int exp_lat, output int lat);
      logic [31:0] r;
      start(s, o, x, y, d);
      wait_valid(lat);
      r = cur_res;
      check(tag, 64'(r), 64'(exp));
      if (exp_lat >= 0) check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      consume();
      check({tag, "_ack"}, 64'(cur_valid), 64'd0);
   endtask

   task automatic count_valid(input int cycles, output int hits);
      hits = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (cur_valid) hits++;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int hits;
      sel = 0; rst = 1'b1; req_valid = 1'b0; req_ready = 1'b0; kill = 1'b0; dit = 1'b0;
      op = 3'b000; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 64'(cur_ready), 64'd1);
      check("rst_valid", 64'(cur_valid), 64'd0);
      check("rst_busy", 64'(cur_busy), 64'd0);
      check("rst_result", 64'(cur_res), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Multiply
      run("mul_dit", 0, 3'b000, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 34, lat);
      run("mul_fast", 0, 3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFEB, -1, lat);
      check("mul_fast_shorter", 64'(lat < 34), 64'd1);
      run("mulh", 0, 3'b001, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, -1, lat);
      run("mulhu", 0, 3'b011, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, -1, lat);
      run("mulhsu", 0, 3'b010, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'hC000_0000, -1, lat);

      // Divide, STEPS=1 then STEPS=4
      run("div", 0, 3'b100, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 34, lat);
      run("rem", 0, 3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, -1, lat);
      run("divu", 0, 3'b101, 32'd100, 32'd7, 1'b0, 32'd14, -1, lat);
      run("remu", 0, 3'b111, 32'd100, 32'd7, 1'b1, 32'd2, 34, lat);
      run("div_s4", 1, 3'b100, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 10, lat);
      run("rem_s4", 1, 3'b110, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 10, lat);
      run("divu_s4", 1, 3'b101, 32'd100, 32'd7, 1'b1, 32'd14, 10, lat);
      run("remu_s4", 1, 3'b111, 32'd100, 32'd7, 1'b1, 32'd2, 10, lat);
      run("mul_s4", 1, 3'b000, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 10, lat);

      // Divide by zero and signed overflow
      run("div0_fast", 0, 3'b100, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 0, lat);
      run("remu0_dit", 0, 3'b111, 32'd5, 32'd0, 1'b1, 32'd5, 34, lat);
      run("div0_neg_dit", 0, 3'b100, 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 34, lat);
      run("rem0_neg_dit", 0, 3'b110, 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFF9, 34, lat);
      run("div_ovf", 0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, -1, lat);
      run("rem_ovf", 0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 34, lat);

      // Output held while ready_i is low
      start(0, 3'b000, 32'd3, 32'd5, 1'b0);
      wait_valid(lat);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("hold_valid", 64'(cur_valid), 64'd1);
         check("hold_result", 64'(cur_res), 64'd15);
      end
      consume();
      check("hold_ack_valid", 64'(cur_valid), 64'd0);
      check("hold_keep_result", 64'(cur_res), 64'd15);

      // Kill during COMP
      start(0, 3'b000, 32'h1234, 32'h10, 1'b1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      kill = 1'b1;
      @(posedge clk);
      #1;
      check("kill_ready", 64'(cur_ready), 64'd1);
      check("kill_busy", 64'(cur_busy), 64'd0);
      check("kill_valid", 64'(cur_valid), 64'd0);
      check("kill_result", 64'(cur_res), 64'd15);
      @(negedge clk);
      kill = 1'b0;
      count_valid(40, hits);
      check("kill_no_valid", 64'(hits), 64'd0);
      run("after_kill", 0, 3'b000, 32'd6, 32'd7, 1'b0, 32'd42, -1, lat);

      // Reset during COMP
      start(0, 3'b101, 32'd1000, 32'd3, 1'b1);
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mrst_ready", 64'(cur_ready), 64'd1);
      check("mrst_busy", 64'(cur_busy), 64'd0);
      check("mrst_valid", 64'(cur_valid), 64'd0);
      check("mrst_result", 64'(cur_res), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      count_valid(40, hits);
      check("mrst_no_valid", 64'(hits), 64'd0);
      run("after_rst", 0, 3'b000, 32'd3, 32'd4, 1'b1, 32'd12, 34, lat);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
